// File: rtl/seq_divider.sv
// Multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; divide-by-zero and signed overflow bypass the iteration.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic             neg_q_q, neg_q_d;
  logic             neg_r_q, neg_r_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic             sgn, a_neg, b_neg, div0, ovf;
  logic [WIDTH-1:0] a_abs, b_abs, res_w, rem_lo;
  logic [WIDTH:0]   rem_sh, trial;

  assign sgn    = ~op[0];
  assign a_neg  = sgn & dividend[WIDTH-1];
  assign b_neg  = sgn & divisor[WIDTH-1];
  assign a_abs  = a_neg ? (~dividend + 1'b1) : dividend;
  assign b_abs  = b_neg ? (~divisor + 1'b1) : divisor;
  assign div0   = (divisor == '0);
  assign ovf    = sgn & (dividend == {1'b1, {(WIDTH-1){1'b0}}}) & (divisor == '1);

  assign rem_sh = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
  assign trial  = rem_sh - {1'b0, dvs_q};
  assign rem_lo = rem_q[WIDTH-1:0];
  assign res_w  = op_q[1] ? (neg_r_q ? (~rem_lo + 1'b1) : rem_lo)
                          : (neg_q_q ? (~quo_q + 1'b1) : quo_q);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          state_d = CALC;
          op_d    = op;
          dvs_d   = b_abs;
          // Early-out preloads Q/R so the normal result mux yields the answer
          // after one pass through CALC with the counter already exhausted.
          if (div0) begin
            neg_q_d = 1'b0;
            neg_r_d = 1'b0;
            quo_d   = '1;
            rem_d   = {1'b0, dividend};
            cnt_d   = CW'(WIDTH);
          end else if (ovf) begin
            neg_q_d = 1'b0;
            neg_r_d = 1'b0;
            quo_d   = dividend;
            rem_d   = '0;
            cnt_d   = CW'(WIDTH);
          end else begin
            neg_q_d = a_neg ^ b_neg;
            neg_r_d = a_neg;
            quo_d   = a_abs;
            rem_d   = '0;
            cnt_d   = '0;
          end
        end
      end
      CALC: begin
        if (flush) begin
          state_d = IDLE;
        end else if (cnt_q == CW'(WIDTH)) begin
          state_d  = DONE;
          result_d = res_w;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (!trial[WIDTH]) begin
            rem_d = trial;
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = rem_sh;
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE) & ~flush;
  assign result = result_q;
endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed RV32M cases, control corner cases,
// and random operations checked against plain-arithmetic division.
module tb_seq_divider;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] dividend, divisor;
  logic        flush;
  logic        busy, done;
  logic [31:0] result;

  int n_cmp = 0;
  int n_err = 0;

  seq_divider #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .dividend(dividend),
    .divisor(divisor), .flush(flush), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // RISC-V division semantics straight from the ISA rules.
  function automatic logic [31:0] ref_res(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'h0 : 32'h8000_0000;
    if (!o[0]) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return o[1] ? r : q;
  endfunction

  function automatic int ref_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    if (b == 0) return 1;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Launch one op with start pulsed for a single cycle; returns in the done cycle (+1).
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int lat;
    @(posedge clk);
    @(negedge clk);
    start = 1'b1; op = o; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, lat, ref_lat(o, a, b));
    chk({tag, "_res"}, result, ref_res(o, a, b));
  endtask

  initial begin
    int lat;
    int pulses;
    logic [31:0] prior, a, b;
    logic [1:0]  o;
    rst = 1'b1; start = 1'b0; op = 2'b00; dividend = '0; divisor = '0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    @(negedge clk); rst = 1'b0;

    run_op("divu_100_7", 2'b01, 32'd100, 32'd7);
    chk("divu_100_7_const", result, 32'd14);
    run_op("remu_100_7", 2'b11, 32'd100, 32'd7);
    chk("remu_100_7_const", result, 32'd2);
    run_op("div_m7_2", 2'b00, -32'sd7, 32'd2);
    chk("div_m7_2_const", result, 32'hFFFF_FFFD);
    run_op("rem_m7_2", 2'b10, -32'sd7, 32'd2);
    chk("rem_m7_2_const", result, 32'hFFFF_FFFF);
    run_op("div_7_m2", 2'b00, 32'd7, -32'sd2);
    run_op("rem_7_m2", 2'b10, 32'd7, -32'sd2);
    chk("rem_7_m2_const", result, 32'd1);
    run_op("divu_big", 2'b01, 32'hFFFF_FFF9, 32'd2);
    chk("divu_big_const", result, 32'h7FFF_FFFC);
    run_op("divu_z", 2'b01, 32'h1234, 32'd0);
    run_op("rem_z", 2'b10, 32'h1234, 32'd0);
    run_op("div_z_neg", 2'b00, 32'h8000_0001, 32'd0);
    run_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("divu_noovf", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("remu_full", 2'b11, 32'hFFFF_FFFF, 32'h8000_0001);

    // start requested during DONE must be ignored
    @(negedge clk);
    start = 1'b1; op = 2'b01; dividend = 32'd50; divisor = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_in_done_busy", {31'b0, busy}, 32'd0);

    // start held high with changing operands: only the first is used
    @(negedge clk);
    start = 1'b1; op = 2'b01; dividend = 32'd100; divisor = 32'd7;
    lat = -1;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (!done) begin
        dividend = $urandom; divisor = $urandom; op = 2'($urandom);
      end
    end
    start = 1'b0;
    chk("hold_start_lat", lat, 32'd33);
    chk("hold_start_res", result, 32'd14);

    // flush in the 10th CALC cycle
    prior = result;
    @(posedge clk);
    @(negedge clk);
    start = 1'b1; op = 2'b01; dividend = 32'd999; divisor = 32'd3;
    @(posedge clk); #1; start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    chk("flush_busy", {31'b0, busy}, 32'd0);
    pulses = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    chk("flush_no_done", pulses, 32'd0);
    chk("flush_result", result, prior);

    // flush during DONE suppresses the pulse; result already registered
    run_op("pre_flush_done", 2'b00, -32'sd100, 32'd9);
    flush = 1'b1;
    #1;
    chk("flush_done_forced", {31'b0, done}, 32'd0);
    @(posedge clk); #1; flush = 1'b0;
    chk("flush_done_busy", {31'b0, busy}, 32'd0);
    chk("flush_done_res", result, ref_res(2'b00, -32'sd100, 32'd9));

    // flush in IDLE drops a simultaneous start
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 2'b01; dividend = 32'd8; divisor = 32'd2;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk("flush_idle_start", {31'b0, busy}, 32'd0);

    // reset 20 cycles into CALC
    @(negedge clk);
    start = 1'b1; op = 2'b11; dividend = 32'd12345; divisor = 32'd17;
    @(posedge clk); #1; start = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_busy", {31'b0, busy}, 32'd0);
    chk("rst_mid_done", {31'b0, done}, 32'd0);
    chk("rst_mid_result", result, 32'd0);
    @(negedge clk); rst = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    chk("rst_mid_no_done", pulses, 32'd0);

    // random operations, biased toward small, zero and extreme operands
    for (int i = 0; i < 30; i++) begin
      o = 2'($urandom);
      case ($urandom_range(0, 4))
        0: a = 32'h8000_0000;
        1: a = $urandom_range(0, 20);
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = $urandom_range(1, 20);
        default: b = $urandom;
      endcase
      run_op("rand", o, a, b);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
